apb_to_streams: RTL and testbench
=================================

# apb_to_streams

APB completer that bridges bus accesses onto a pair of 8-bit byte streams: writes to a data register push bytes into a transmit FIFO drained by `out_*`, and reads pop bytes from a receive FIFO filled by `in_*`. It sits on the same 8-bit APB bus driven by the byte-stream initiator and gives software-visible stream endpoints on the completer side. Optional wait-state insertion gives flow control.

## Interface
- `BASE_ADDR`, default 8'h00: address of register 0; the block decodes `BASE_ADDR`..`BASE_ADDR+2`.
- `DEPTH`, default 4: entries per FIFO; power of two, ≥2.
- `CLK`  in  1  clock.
- `RESETn`  in  1  reset; synchronous, active-low.
- `PSEL`, `PENABLE`, `PWRITE`  in  1  APB control.
- `PADDR`  in  8  APB address.
- `PWDATA`  in  8  APB write data.
- `PRDATA`  out  8  APB read data.
- `PREADY`  out  1  APB ready / wait-state control.
- `out_data`  out  8  TX stream byte (FIFO head).
- `out_valid`  out  1  TX FIFO not empty.
- `out_ready`  in  1  TX consumer accepts.
- `in_data`  in  8  RX stream byte.
- `in_valid`  in  1  RX producer offers.
- `in_ready`  out  1  RX FIFO not full.

## Operation
- Register map, with offsets from `BASE_ADDR`:
  - Offset 0, DATA: a write pushes `PWDATA` into TX. A read pops the RX head and returns it.
  - Offset 1, STATUS: bit0 TX not full; bit1 RX not empty; [4:2] RX level, saturating at 7; bit5 0; bit6 sticky overflow; bit7 sticky underflow. A write of 1 to bit6 or bit7 clears that flag; other bits are read-only.
  - Offset 2, CTRL: bit0 TX flush and bit1 RX flush are write-1 pulses that read as 0. Bit2 BLOCK is R/W, reset value 1. Bits [7:3] read 0.
  - Unmapped address: reads return 0x00, writes are ignored, `PREADY`=1.
- Transfer completes on the edge where `PSEL&PENABLE&PREADY`=1. All side effects (push, pop, flag clear, flush, CTRL update) occur only on that edge, exactly once per transfer.
- BLOCK=1:
  - DATA write with TX full holds `PREADY`=0 until TX has space.
  - DATA read with RX empty holds `PREADY`=0 until RX has data.
- BLOCK=0:
  - DATA write with TX full completes immediately, drops the byte and sets overflow.
  - DATA read with RX empty completes immediately, returns 0x00 and sets underflow.
- BLOCK can be changed only by a completed CTRL write. It has no effect on a stall already in progress until that stall ends.
- FIFO behaviour:
  - TX pops on `out_valid&out_ready`; RX pushes on `in_valid&in_ready`. Both FIFOs are first-in first-out with wrap-around pointers; occupancy counter width is clog2(DEPTH)+1.
  - No bypass. A byte pushed into an empty FIFO is visible to its consumer the following cycle. A full FIFO stays full in a cycle where it is also being popped; space appears the next cycle.
- Flush:
  - The FIFO is empty after the flush edge.
  - An RX stream push on the flush edge is discarded.
  - A TX stream pop on the flush edge is a completed transfer.
  - Flush does not change the sticky flags.

## Timing
- Reset values: `PRDATA`=0x00, `PREADY`=1, `out_valid`=0, `out_data`=0x00, `in_ready`=1. Both FIFOs are empty, both sticky flags are 0, BLOCK=1.
- Reset is honoured mid-transfer, including during a stall: the transfer is abandoned with no side effect and `PREADY` returns to 1.
- `PREADY` is combinational:
  - It is 0 only during an access phase (`PSEL&PENABLE`) to DATA with BLOCK=1 and the relevant FIFO blocked.
  - It is 1 at all other times.
  - With no stall, every access completes in the standard 2-cycle setup + access.
- `PRDATA` is combinational:
  - It is valid during an access phase while `PREADY`=1.
  - It is 0x00 whenever not `PSEL&PENABLE`.
  - It is 0x00 during a write.
  - It is 0x00 during a stalled cycle.
- Stall release: `PREADY` rises in the first cycle in which the blocking condition is false, following the registered FIFO state, i.e. one cycle after the stream transfer that resolved it.
- Simultaneous events on one edge:
  - An APB STATUS W1C and a new overflow/underflow cannot coincide, since they are different addresses.
  - An RX push and an APB pop on a non-empty RX leave the level unchanged.
  - A TX push and a stream pop on a non-full TX leave the level unchanged.
- Latency:
  - APB write to `out_valid`: 1 cycle after the completing edge.
  - `in_*` transfer to the byte being readable: the next cycle.

## Test plan
- After reset, read STATUS → 0x01 and CTRL → 0x04. Hold `out_ready`=0, write 0x11, 0x22, 0x33, 0x44 to DATA → STATUS bit0=0, `out_valid`=1, `out_data`=0x11. Raise `out_ready` → bytes 0x11..0x44 emerge in order on consecutive cycles.
- BLOCK=1 with TX full: write 0x55 → `PREADY` stays 0. Pulse `out_ready` for one transfer → `PREADY` rises the following cycle, and 0x55 is emitted last, after the bytes ahead of it.
- BLOCK=0 (write CTRL=0x00): a fifth DATA write completes with no wait → STATUS bit6=1, byte dropped. Write STATUS=0x40 → bit6=0. A read of DATA with RX empty returns 0x00 and sets bit7.
- Stream in 0xA1, 0xB2, 0xC3 → STATUS=0x0E; DATA reads return 0xA1, 0xB2, 0xC3. `in_ready` falls after DEPTH bytes and rises the cycle after a pop.
- BLOCK=1 with RX empty: DATA read stalls; drive `in_valid` with 0x7E → read completes the next cycle returning 0x7E. Write CTRL=0x07 → both FIFOs empty, and BLOCK reads back 1.
- Assert RESETn=0 during a stalled DATA write → `PREADY`=1, `out_valid`=0 and STATUS=0x01 after reset, with no byte emitted.

Source files
------------

// File: rtl/apb_if.sv
// APB bus bundle for the 8-bit stream bridge.
// The requester drives the control, address and write data; the completer returns read data and ready.
interface apb_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_to_streams.sv
// APB completer that bridges DATA register accesses onto a TX and an RX byte stream.
// Each stream has its own FIFO, and the completer can insert wait states when the BLOCK bit is set.
module apb_to_streams #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       RESETn,
  apb_if.slave       apb,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0] off;
  logic       access, sel_data, sel_status, sel_ctrl;
  logic       stall, done;
  logic       wr_data, rd_data, wr_status, wr_ctrl;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_flush;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_flush;

  logic       ovf, udf, block;
  logic [2:0] rx_lvl;
  logic [7:0] status;

  assign off        = apb.PADDR - BASE_ADDR;
  assign access     = apb.PSEL & apb.PENABLE;
  assign sel_data   = (off == 8'd0);
  assign sel_status = (off == 8'd1);
  assign sel_ctrl   = (off == 8'd2);

  // Wait states only come from DATA accesses; the condition follows the registered FIFO state.
  assign stall      = access & sel_data & block & (apb.PWRITE ? tx_full : rx_empty);
  assign apb.PREADY = ~stall;
  assign done       = access & ~stall;

  assign wr_data   = done & sel_data & apb.PWRITE;
  assign rd_data   = done & sel_data & ~apb.PWRITE;
  assign wr_status = done & sel_status & apb.PWRITE;
  assign wr_ctrl   = done & sel_ctrl & apb.PWRITE;

  assign tx_full  = (tx_cnt == FULL);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = wr_data & ~tx_full;
  assign tx_pop   = ~tx_empty & out_ready;
  assign tx_flush = wr_ctrl & apb.PWDATA[0];

  assign rx_full  = (rx_cnt == FULL);
  assign rx_empty = (rx_cnt == '0);
  assign rx_push  = in_valid & ~rx_full;
  assign rx_pop   = rd_data & ~rx_empty;
  assign rx_flush = wr_ctrl & apb.PWDATA[1];

  assign out_valid = ~tx_empty;
  assign out_data  = tx_empty ? 8'h00 : tx_mem[tx_rp];
  assign in_ready  = ~rx_full;

  always_ff @(posedge CLK) begin
    if (!RESETn || tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp] <= apb.PWDATA;
  end

  // A flush on the same edge as a stream push wins, so that byte is discarded.
  always_ff @(posedge CLK) begin
    if (!RESETn || rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem[rx_wp] <= in_data;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      ovf   <= 1'b0;
      udf   <= 1'b0;
      block <= 1'b1;
    end else begin
      if (wr_data && tx_full)                ovf <= 1'b1;
      else if (wr_status && apb.PWDATA[6])   ovf <= 1'b0;
      if (rd_data && rx_empty)               udf <= 1'b1;
      else if (wr_status && apb.PWDATA[7])   udf <= 1'b0;
      if (wr_ctrl)                           block <= apb.PWDATA[2];
    end
  end

  always_comb begin
    rx_lvl = 3'(rx_cnt);
    if (32'(rx_cnt) > 32'd7) rx_lvl = 3'd7;
  end

  assign status = {udf, ovf, 1'b0, rx_lvl, ~rx_empty, ~tx_full};

  always_comb begin
    apb.PRDATA = 8'h00;
    if (done && !apb.PWRITE) begin
      case (off)
        8'd0:    apb.PRDATA = rx_empty ? 8'h00 : rx_mem[rx_rp];
        8'd1:    apb.PRDATA = status;
        8'd2:    apb.PRDATA = {5'b0, block, 2'b0};
        default: apb.PRDATA = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_to_streams.sv
// Self-checking bench for apb_to_streams.
// It runs table-driven register vectors, directed stall/flush/reset sequences and random traffic against a queue-based model.
module tb_apb_to_streams;
  localparam logic [7:0] B = 8'h40;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;

  apb_if bus();

  apb_to_streams #(.BASE_ADDR(B), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESETn(RESETn), .apb(bus),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte queues plus flags, advanced once per clock edge.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit m_ovf = 0, m_udf = 0, m_block = 1, mdl_on = 0;
  logic [7:0] tx_seen[$];
  int tx_stamp[$];

  task automatic model_step();
    logic acc;
    logic [7:0] off, exp_rd, st;
    int txn, rxn;
    bit stall, done;
    acc = bus.PSEL && bus.PENABLE;
    off = bus.PADDR - B;
    txn = m_tx.size();
    rxn = m_rx.size();
    stall = acc && off == 8'd0 && m_block && (bus.PWRITE ? txn == DEPTH : rxn == 0);
    done = acc && !stall;
    st = {m_udf, m_ovf, 1'b0, 3'((rxn > 7) ? 7 : rxn), rxn > 0, txn < DEPTH};
    exp_rd = 8'h00;
    if (done && !bus.PWRITE) begin
      case (off)
        8'd0: exp_rd = (rxn > 0) ? m_rx[0] : 8'h00;
        8'd1: exp_rd = st;
        8'd2: exp_rd = {5'b0, m_block, 2'b0};
        default: exp_rd = 8'h00;
      endcase
    end
    chk("pready", 8'(bus.PREADY), 8'(!stall));
    chk("prdata", bus.PRDATA, exp_rd);
    chk("out_valid", 8'(out_valid), 8'(txn > 0));
    chk("out_data", out_data, (txn > 0) ? m_tx[0] : 8'h00);
    chk("in_ready", 8'(in_ready), 8'(rxn < DEPTH));
    if (RESETn && out_valid === 1'b1 && out_ready) begin
      tx_seen.push_back(out_data);
      tx_stamp.push_back(cyc);
    end
    if (!RESETn) begin
      m_tx.delete(); m_rx.delete();
      m_ovf = 0; m_udf = 0; m_block = 1;
      return;
    end
    if (txn > 0 && out_ready) void'(m_tx.pop_front());
    if (done && off == 8'd0 && bus.PWRITE) begin
      if (txn == DEPTH) m_ovf = 1; else m_tx.push_back(bus.PWDATA);
    end
    if (done && off == 8'd0 && !bus.PWRITE) begin
      if (rxn == 0) m_udf = 1; else void'(m_rx.pop_front());
    end
    if (rxn < DEPTH && in_valid) m_rx.push_back(in_data);
    if (done && off == 8'd1 && bus.PWRITE) begin
      if (bus.PWDATA[6]) m_ovf = 0;
      if (bus.PWDATA[7]) m_udf = 0;
    end
    if (done && off == 8'd2 && bus.PWRITE) begin
      m_block = bus.PWDATA[2];
      if (bus.PWDATA[0]) m_tx.delete();
      if (bus.PWDATA[1]) m_rx.delete();
    end
  endtask

  always begin
    @(negedge CLK);
    #3;
    cyc++;
    if (mdl_on) model_step();
  end

  task automatic apb(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output int waits);
    @(negedge CLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd;
    @(negedge CLK);
    bus.PENABLE = 1'b1;
    #1;
    waits = 0;
    while (bus.PREADY !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge CLK);
      #1;
    end
    if (bus.PREADY !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL apb_timeout: addr %h still waiting after %0d cycles", addr, waits);
    end
    rd = bus.PRDATA;
    @(negedge CLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  function automatic logic [7:0] seen_at(int i);
    return (i < tx_seen.size()) ? tx_seen[i] : 8'hxx;
  endfunction

  typedef struct {
    bit         wr;
    logic [7:0] off;
    logic [7:0] wd;
    logic [7:0] rd;
    int         waits;
  } vec_t;

  vec_t tbl[11];
  logic [7:0] exp5[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] exp4[4] = '{8'h61, 8'h62, 8'h63, 8'h64};
  logic [7:0] rxb[4]  = '{8'hD4, 8'hE5, 8'hF6, 8'h17};

  initial begin
    logic [7:0] rd, addr, wd;
    int w, sel;
    bit wr, rnd_on;

    tbl[0]  = '{0, 8'h01, 8'h00, 8'h01, 0};
    tbl[1]  = '{0, 8'h02, 8'h00, 8'h04, 0};
    tbl[2]  = '{0, 8'h03, 8'h00, 8'h00, 0};
    tbl[3]  = '{1, 8'h03, 8'hFF, 8'h00, 0};
    tbl[4]  = '{0, 8'hFF, 8'h00, 8'h00, 0};
    tbl[5]  = '{1, 8'h00, 8'h11, 8'h00, 0};
    tbl[6]  = '{1, 8'h00, 8'h22, 8'h00, 0};
    tbl[7]  = '{1, 8'h00, 8'h33, 8'h00, 0};
    tbl[8]  = '{1, 8'h00, 8'h44, 8'h00, 0};
    tbl[9]  = '{0, 8'h01, 8'h00, 8'h00, 0};
    tbl[10] = '{0, 8'h02, 8'h00, 8'h04, 0};

    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h00; bus.PWDATA = 8'h00;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    mdl_on = 1;

    foreach (tbl[i]) begin
      apb(tbl[i].wr, B + tbl[i].off, tbl[i].wd, rd, w);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_waits", i), 8'(w), 8'(tbl[i].waits));
    end
    #1;
    chk("tx_head_valid", 8'(out_valid), 8'h01);
    chk("tx_head_data", out_data, 8'h11);

    // TX full with BLOCK=1: one stream pop releases the stalled write a cycle later.
    tx_seen.delete(); tx_stamp.delete();
    fork
      apb(1, B, 8'h55, rd, w);
      begin
        repeat (4) @(negedge CLK);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
      end
    join
    chk("tx_stall_waits", 8'(w), 8'd3);
    @(negedge CLK); out_ready = 1'b1;
    repeat (6) @(negedge CLK);
    out_ready = 1'b0;
    chk("tx_drain_count", 8'(tx_seen.size()), 8'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("tx_order%0d", i), seen_at(i), exp5[i]);
    if (tx_stamp.size() == 5) chk("tx_back_to_back", 8'(tx_stamp[4] - tx_stamp[1]), 8'd3);
    else chk("tx_stamp_count", 8'(tx_stamp.size()), 8'd5);

    // BLOCK=0: overflow and underflow instead of wait states.
    apb(1, B + 8'd2, 8'h00, rd, w);
    for (int i = 0; i < 4; i++) apb(1, B, exp4[i], rd, w);
    apb(1, B, 8'h65, rd, w);
    chk("ovf_write_waits", 8'(w), 8'd0);
    apb(0, B + 8'd1, 8'h00, rd, w);  chk("status_ovf", rd, 8'h40);
    apb(1, B + 8'd1, 8'h40, rd, w);
    apb(0, B + 8'd1, 8'h00, rd, w);  chk("status_ovf_clr", rd, 8'h00);
    apb(0, B, 8'h00, rd, w);
    chk("udf_read_data", rd, 8'h00);
    chk("udf_read_waits", 8'(w), 8'd0);
    apb(0, B + 8'd1, 8'h00, rd, w);  chk("status_udf", rd, 8'h80);
    apb(1, B + 8'd1, 8'h80, rd, w);

    // RX stream in, level reporting, in_ready back-pressure.
    @(negedge CLK); in_valid = 1'b1; in_data = 8'hA1;
    @(negedge CLK); in_data = 8'hB2;
    @(negedge CLK); in_data = 8'hC3;
    @(negedge CLK); in_valid = 1'b0;
    apb(0, B + 8'd1, 8'h00, rd, w);  chk("status_rx3", rd, 8'h0E);
    apb(0, B, 8'h00, rd, w);         chk("rx_pop0", rd, 8'hA1);
    apb(0, B, 8'h00, rd, w);         chk("rx_pop1", rd, 8'hB2);
    apb(0, B, 8'h00, rd, w);         chk("rx_pop2", rd, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); in_valid = 1'b1; in_data = rxb[i];
    end
    @(negedge CLK); in_valid = 1'b0;
    #1;
    chk("in_ready_full", 8'(in_ready), 8'h00);
    apb(0, B + 8'd1, 8'h00, rd, w);  chk("status_rx4", rd, 8'h12);
    apb(0, B, 8'h00, rd, w);         chk("rx_pop_full", rd, 8'hD4);
    #1;
    chk("in_ready_after_pop", 8'(in_ready), 8'h01);

    tx_seen.delete(); tx_stamp.delete();
    @(negedge CLK); out_ready = 1'b1;
    repeat (6) @(negedge CLK);
    out_ready = 1'b0;
    chk("ovf_drain_count", 8'(tx_seen.size()), 8'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_order%0d", i), seen_at(i), exp4[i]);

    // RX empty with BLOCK=1: the read waits for a stream byte.
    apb(1, B + 8'd2, 8'h06, rd, w);
    fork
      apb(0, B, 8'h00, rd, w);
      begin
        repeat (4) @(negedge CLK);
        in_valid = 1'b1; in_data = 8'h7E;
        @(negedge CLK);
        in_valid = 1'b0;
      end
    join
    chk("rx_stall_data", rd, 8'h7E);
    chk("rx_stall_waits", 8'(w), 8'd3);

    apb(1, B, 8'h99, rd, w);
    @(negedge CLK); in_valid = 1'b1; in_data = 8'h5A;
    @(negedge CLK); in_valid = 1'b0;
    apb(1, B + 8'd2, 8'h07, rd, w);
    apb(0, B + 8'd1, 8'h00, rd, w);  chk("status_flushed", rd, 8'h01);
    apb(0, B + 8'd2, 8'h00, rd, w);  chk("ctrl_block_kept", rd, 8'h04);
    #1;
    chk("tx_empty_after_flush", 8'(out_valid), 8'h00);

    // Reset while a DATA write is stalled on a full TX FIFO.
    for (int i = 0; i < 4; i++) apb(1, B, 8'h31 + 8'(i), rd, w);
    tx_seen.delete(); tx_stamp.delete();
    @(negedge CLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = B; bus.PWDATA = 8'h35;
    @(negedge CLK); bus.PENABLE = 1'b1;
    @(negedge CLK); #1;
    chk("rst_stall_pready", 8'(bus.PREADY), 8'h00);
    @(negedge CLK); RESETn = 1'b0;
    @(negedge CLK); #1;
    chk("rst_pready", 8'(bus.PREADY), 8'h01);
    chk("rst_out_valid", 8'(out_valid), 8'h00);
    @(negedge CLK);
    RESETn = 1'b1; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge CLK);
    out_ready = 1'b0;
    chk("rst_no_emit", 8'(tx_seen.size()), 8'd0);
    apb(0, B + 8'd1, 8'h00, rd, w);  chk("rst_status", rd, 8'h01);

    // Random traffic, checked cycle by cycle by the model.
    rnd_on = 1;
    fork
      begin
        for (int k = 0; k < 250; k++) begin
          sel  = $urandom_range(0, 4);
          wr   = 1'($urandom_range(0, 1));
          addr = (sel == 4) ? 8'($urandom) : B + 8'(sel);
          wd   = 8'($urandom);
          apb(wr, addr, wd, rd, w);
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(negedge CLK);
          out_ready = ($urandom_range(0, 3) != 0);
          in_valid  = 1'($urandom_range(0, 1));
          in_data   = 8'($urandom);
        end
      end
    join
    out_ready = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
